// File: rtl/div_result_check_pkg.sv
// Shared definitions for the divider result checker: state encoding,
// default widths, status bit positions and a saturating counter helper.
package div_pkg;
  localparam int QW = 16;
  localparam int DW = 2 * QW;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_CHK  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // Status bit positions, as used by the divider test harness.
  localparam int ST_PASS    = 0;
  localparam int ST_REM_ERR = 1;
  localparam int ST_DIV0    = 2;
  localparam int ST_W       = 3;

  // Increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/div_result_check_if.sv
// Tuple-in / result-out handshake bundle for div_result_check.
// master: the side that supplies tuples and consumes results.
// slave : the checker itself.
interface div_result_check_if #(parameter int QW = 16) ();
  logic              in_valid;
  logic              in_ready;
  logic [2*QW-1:0]   dd;
  logic [QW-1:0]     dv;
  logic [QW-1:0]     qt;
  logic [QW-1:0]     rm;
  logic              out_valid;
  logic              out_ready;
  logic [2*QW:0]     recon;
  logic              rem_err;
  logic              div0;
  logic              pass;

  modport master (
    output in_valid, dd, dv, qt, rm, out_ready,
    input  in_ready, out_valid, recon, rem_err, div0, pass
  );

  modport slave (
    input  in_valid, dd, dv, qt, rm, out_ready,
    output in_ready, out_valid, recon, rem_err, div0, pass
  );
endinterface

// File: rtl/div_result_check_shift_add_mul.sv
// Sequential shift-add multiplier: acc = addend + mcand_in * mplier_in,
// one multiplier bit per cycle, QW cycles after start. done is high during
// the last step cycle; acc is final on the following cycle.
module shift_add_mul #(
  parameter int QW = 16,
  parameter int CW = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [QW-1:0]   mcand_in,
  input  logic [QW-1:0]   mplier_in,
  input  logic [QW-1:0]   addend,
  output logic [2*QW:0]   acc,
  output logic            busy,
  output logic            done
);
  logic [2*QW:0]   acc_q, acc_d;
  logic [2*QW-1:0] mcand_q, mcand_d;
  logic [QW-1:0]   mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;

  // Load on start, otherwise one add/shift step per busy cycle.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      acc_d    = {{(QW+1){1'b0}}, addend};
      mcand_d  = {{QW{1'b0}}, mcand_in};
      mplier_d = mplier_in;
      cnt_d    = CW'(QW - 1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + {1'b0, mcand_q};
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - 1'b1;
      if (cnt_q == '0) busy_d = 1'b0;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

  assign acc  = acc_q;
  assign busy = busy_q;
  assign done = busy_q && (cnt_q == '0);
endmodule

// File: rtl/div_result_check.sv
// Divider result checker: rebuilds qt*dv+rm and compares against dd,
// flagging remainder-range errors and divide-by-zero.
// Optional feature macro DIV_CHK_STATS_EN adds saturating pass/fail counters.
module div_result_check
  import div_pkg::*;
#(
  parameter int QW = div_pkg::QW,
  parameter int CW = 5
) (
  input  logic clk,
  input  logic reset,
  div_result_check_if.slave bus
`ifdef DIV_CHK_STATS_EN
  ,
  output logic [15:0] pass_cnt,
  output logic [15:0] fail_cnt
`endif
);
  logic [1:0]      state_q, state_d;
  logic [2*QW-1:0] dd_q, dd_d;
  logic [QW-1:0]   dv_q, dv_d, rm_q, rm_d;
  logic [2*QW:0]   recon_q, recon_d;
  logic            rem_err_q, rem_err_d, div0_q, div0_d, pass_q, pass_d;
  logic            in_ready, out_valid, accept, chk_en, consume;
  logic [2*QW:0]   acc;
  logic            mul_busy, mul_done;

  shift_add_mul #(.QW(QW), .CW(CW)) u_mul (
    .clk       (clk),
    .reset     (reset),
    .start     (accept),
    .mcand_in  (bus.dv),
    .mplier_in (bus.qt),
    .addend    (bus.rm),
    .acc       (acc),
    .busy      (mul_busy),
    .done      (mul_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (bus.in_valid)  state_d = S_MUL;
      S_MUL:   if (mul_done)      state_d = S_CHK;
      S_CHK:                      state_d = S_DONE;
      S_DONE:  if (bus.out_ready) state_d = S_IDLE;
      default:                    state_d = S_IDLE;
    endcase
  end

  // State-decoded controls.
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    chk_en    = (state_q == S_CHK);
    accept    = in_ready && bus.in_valid;
    consume   = out_valid && bus.out_ready;
  end

  // Tuple capture on accept; result compare in CHK, held until the next CHK.
  always_comb begin
    dd_d      = dd_q;
    dv_d      = dv_q;
    rm_d      = rm_q;
    recon_d   = recon_q;
    div0_d    = div0_q;
    rem_err_d = rem_err_q;
    pass_d    = pass_q;
    if (accept) begin
      dd_d = bus.dd;
      dv_d = bus.dv;
      rm_d = bus.rm;
    end
    if (chk_en) begin
      recon_d   = acc;
      div0_d    = (dv_q == '0);
      rem_err_d = (rm_q >= dv_q) || (dv_q == '0);
      pass_d    = (acc == {1'b0, dd_q}) && (rm_q < dv_q) && (dv_q != '0);
    end
  end

  // Capture and result registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dd_q      <= '0;
      dv_q      <= '0;
      rm_q      <= '0;
      recon_q   <= '0;
      div0_q    <= 1'b0;
      rem_err_q <= 1'b0;
      pass_q    <= 1'b0;
    end else begin
      dd_q      <= dd_d;
      dv_q      <= dv_d;
      rm_q      <= rm_d;
      recon_q   <= recon_d;
      div0_q    <= div0_d;
      rem_err_q <= rem_err_d;
      pass_q    <= pass_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.recon     = recon_q;
  assign bus.rem_err   = rem_err_q;
  assign bus.div0      = div0_q;
  assign bus.pass      = pass_q;

`ifdef DIV_CHK_STATS_EN
  logic [15:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;

  // Count each consumed result by its verdict, saturating.
  always_comb begin
    pass_cnt_d = pass_cnt_q;
    fail_cnt_d = fail_cnt_q;
    if (consume) begin
      if (pass_q) pass_cnt_d = sat_inc16(pass_cnt_q);
      else        fail_cnt_d = sat_inc16(fail_cnt_q);
    end
  end

  // Statistics counters, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
    end else begin
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
    end
  end

  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
`else
  logic unused_consume;
  assign unused_consume = consume;
`endif

  logic unused_busy;
  assign unused_busy = mul_busy;
endmodule

// File: tb/tb_div_result_check.sv
// Self-checking bench for div_result_check (QW=16): directed plan vectors,
// randomized tuples against an arithmetic reference, backpressure and
// mid-operation reset. Build with +define+DIV_CHK_STATS_EN to cover counters.
module tb_div_result_check;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  div_result_check_if #(.QW(16)) bus ();
`ifdef DIV_CHK_STATS_EN
  logic [15:0] pass_cnt, fail_cnt;
`endif

  div_result_check #(.QW(16), .CW(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DIV_CHK_STATS_EN
    ,
    .pass_cnt (pass_cnt),
    .fail_cnt (fail_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference: expected result fields from the checking rules.
  function automatic logic [35:0] model(input logic [31:0] a, input logic [15:0] b,
                                        input logic [15:0] q, input logic [15:0] r);
    longint unsigned rc;
    logic z, re, ps;
    rc = longint'(q) * longint'(b) + longint'(r);
    z  = (b == 0);
    re = z || (r >= b);
    ps = (rc == longint'(a)) && !re;
    return {ps, z, re, rc[32:0]};
  endfunction

  // Drive one tuple from IDLE and wait for out_valid; lat counts edges
  // starting with the accept edge (bounded at 40).
  task automatic run_tuple(input logic [31:0] a, input logic [15:0] b,
                           input logic [15:0] q, input logic [15:0] r, output int lat);
    bus.in_valid = 1'b1; bus.dd = a; bus.dv = b; bus.qt = q; bus.rm = r;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    bus.in_valid = 0; bus.dd = 0; bus.dv = 0; bus.qt = 0; bus.rm = 0; bus.out_ready = 1;
    reset = 1'b0;
    #12;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.recon, bus.rem_err, bus.div0, bus.pass} !== {1'b1, 1'b0, 33'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL reset_state: got rdy=%0b vld=%0b recon=%0h re=%0b z=%0b p=%0b, want 1 0 0 0 0 0",
               bus.in_ready, bus.out_valid, bus.recon, bus.rem_err, bus.div0, bus.pass);
    end
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [31:0] ta [4] = '{32'd100, 32'd100, 32'hFFFE0001, 32'd5};
    logic [15:0] tb [4] = '{16'd7, 16'd7, 16'hFFFF, 16'd0};
    logic [15:0] tq [4] = '{16'd14, 16'd14, 16'hFFFF, 16'd0};
    logic [15:0] tr [4] = '{16'd2, 16'd9, 16'd0, 16'd5};
    logic [35:0] want [4] = '{{3'b100, 33'd100}, {3'b001, 33'd107},
                              {3'b100, 33'h0FFFE0001}, {3'b011, 33'd5}};
    int lat;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_tuple(ta[i], tb[i], tq[i], tr[i], lat);
      n_checks++;
      if (lat !== 18) begin
        n_fail++; $display("FAIL dir%0d_latency: got %0d want 18", i, lat);
      end
      n_checks++;
      if ({bus.pass, bus.div0, bus.rem_err, bus.recon} !== want[i]) begin
        n_fail++;
        $display("FAIL dir%0d_result: got p/z/re/recon=%0b%0b%0b/%0h want %0b/%0h",
                 i, bus.pass, bus.div0, bus.rem_err, bus.recon, want[i][35:33], want[i][32:0]);
      end
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL dir%0d_release: got vld=%0b rdy=%0b want 0 1", i, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] a; logic [15:0] b, q, r;
    logic [35:0] want;
    int lat, mode;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      q = 16'($urandom_range(0, 65535));
      b = 16'($urandom_range(1, 65535));
      r = 16'($urandom_range(0, int'(b) - 1));
      a = 32'(q * b + r);
      mode = $urandom_range(0, 3);
      if (mode == 1) a = a ^ (32'd1 << $urandom_range(0, 31));
      if (mode == 2) r = 16'($urandom_range(int'(b), 65535));
      if (mode == 3) b = 16'd0;
      want = model(a, b, q, r);
      run_tuple(a, b, q, r, lat);
      n_checks++;
      if (lat !== 18 || {bus.pass, bus.div0, bus.rem_err, bus.recon} !== want) begin
        n_fail++;
        $display("FAIL rand%0d: dd=%0h dv=%0h qt=%0h rm=%0h got lat=%0d p/z/re=%0b%0b%0b recon=%0h want lat=18 %0b recon=%0h",
                 i, a, b, q, r, lat, bus.pass, bus.div0, bus.rem_err, bus.recon, want[35:33], want[32:0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure();
    logic [35:0] held, want;
    int lat;
    bus.out_ready = 1'b0;
    run_tuple(32'd100, 16'd7, 16'd14, 16'd9, lat);
    held = {bus.pass, bus.div0, bus.rem_err, bus.recon};
    bus.in_valid = 1'b1; bus.dd = 32'd1000; bus.dv = 16'd10; bus.qt = 16'd100; bus.rm = 16'd0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.pass, bus.div0, bus.rem_err, bus.recon} !== held || held !== {3'b001, 33'd107}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got vld=%0b rdy=%0b out=%0h want vld=1 rdy=0 out=%0h",
                 i, bus.out_valid, bus.in_ready, {bus.pass, bus.div0, bus.rem_err, bus.recon}, {3'b001, 33'd107});
      end
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release: got vld=%0b rdy=%0b want 0 1", bus.out_valid, bus.in_ready);
    end
    want = model(32'd1000, 16'd10, 16'd100, 16'd0);
    run_tuple(32'd1000, 16'd10, 16'd100, 16'd0, lat);
    n_checks++;
    if (lat !== 18 || {bus.pass, bus.div0, bus.rem_err, bus.recon} !== want) begin
      n_fail++;
      $display("FAIL bp_new_tuple: got lat=%0d out=%0h want lat=18 out=%0h",
               lat, {bus.pass, bus.div0, bus.rem_err, bus.recon}, want);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int lat, seen;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.dd = 32'd100; bus.dv = 16'd7; bus.qt = 16'd14; bus.rm = 16'd2;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    n_checks++;
    if ({bus.in_ready, bus.out_valid, bus.recon, bus.rem_err, bus.div0, bus.pass} !== {1'b1, 1'b0, 33'd0, 3'b000}) begin
      n_fail++;
      $display("FAIL midreset_state: got rdy=%0b vld=%0b recon=%0h re/z/p=%0b%0b%0b want 1 0 0 000",
               bus.in_ready, bus.out_valid, bus.recon, bus.rem_err, bus.div0, bus.pass);
    end
`ifdef DIV_CHK_STATS_EN
    n_checks++;
    if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0) begin
      n_fail++; $display("FAIL midreset_stats_clear: got %0d/%0d want 0/0", pass_cnt, fail_cnt);
    end
`endif
    #1 reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid !== 1'b0) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midreset_no_valid: got %0d valid cycles want 0", seen);
    end
    run_tuple(32'd100, 16'd7, 16'd14, 16'd2, lat);
    n_checks++;
    if (lat !== 18 || bus.pass !== 1'b1 || bus.recon !== 33'd100) begin
      n_fail++; $display("FAIL midreset_next: got lat=%0d pass=%0b recon=%0h want 18 1 64", lat, bus.pass, bus.recon);
    end
    @(posedge clk); #1;
`ifdef DIV_CHK_STATS_EN
    n_checks++;
    if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0) begin
      n_fail++; $display("FAIL midreset_stats: got pass_cnt=%0d fail_cnt=%0d want 1 0", pass_cnt, fail_cnt);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
